// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed or
// unsigned operands per operation, valid/ready handshakes on both sides.
module booth_radix4_seq #(
    parameter int unsigned WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int unsigned EXT   = WIDTH + 2 + (WIDTH % 2);
    localparam int unsigned STEPS = EXT / 2;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned AW    = 2 * EXT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] a_q, a_d;        // multiplicand, pre-shifted by 2i
    logic [EXT-1:0] m_q, m_d;       // multiplier, shifted right by 2i
    logic          mprev_q, mprev_d; // m[2i-1]
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] out_d;
    logic [AW-1:0] sel;
    logic          accept;
    logic          ext1, ext2;

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign ext1     = in_signed & in1[WIDTH-1];
    assign ext2     = in_signed & in2[WIDTH-1];

    // Next-state, Booth digit selection and datapath updates
    always_comb begin
        state_nxt = state;
        a_d       = a_q;
        m_d       = m_q;
        mprev_d   = mprev_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out;
        sel       = '0;

        case ({m_q[1:0], mprev_q})
            3'b001, 3'b010: sel = a_q;
            3'b011:         sel = AW'(a_q << 1);
            3'b100:         sel = AW'(-(a_q << 1));
            3'b101, 3'b110: sel = AW'(-a_q);
            default:        sel = '0;
        endcase

        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                acc_d   = acc_q + sel;
                a_d     = AW'(a_q << 2);
                m_d     = EXT'(m_q >> 2);
                mprev_d = m_q[1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_nxt = DONE;
                    out_d     = acc_d[PW-1:0];
                    cnt_d     = '0;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Operand capture; extension makes unsigned operands positive in EXT bits
        if (accept) begin
            a_d     = {{(AW - WIDTH){ext1}}, in1};
            m_d     = {{(EXT - WIDTH){ext2}}, in2};
            mprev_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            mprev_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_q       <= a_d;
            m_q       <= m_d;
            mprev_q   <= mprev_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out       <= out_d;
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq at WIDTH=6 and WIDTH=5.
module tb_booth_radix4_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in1 = '0;
    logic [5:0]  in2 = '0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready6, out_valid6, busy6;
    logic [11:0] out6;
    logic        in_ready5, out_valid5, busy5;
    logic [9:0]  out5;

    int nvec = 0;
    int nerr = 0;

    int sq_a[$];
    int sq_b[$];
    bit sq_s[$];

    always #5 clk = ~clk;

    booth_radix4_seq #(.WIDTH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in1(in1), .in2(in2), .in_signed(in_signed), .out_valid(out_valid6),
        .out_ready(out_ready), .out(out6), .busy(busy6)
    );

    booth_radix4_seq #(.WIDTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .in1(in1[4:0]), .in2(in2[4:0]), .in_signed(in_signed), .out_valid(out_valid5),
        .out_ready(out_ready), .out(out5), .busy(busy5)
    );

    // Mathematical product of w-bit patterns a,b (signed or unsigned), mod 2^(2w)
    function automatic logic [63:0] model(input int w, input int a, input int b, input bit s);
        longint full = longint'(1) << w;
        longint x = longint'(a) & (full - 1);
        longint y = longint'(b) & (full - 1);
        if (s && x >= full / 2) x = x - full;
        if (s && y >= full / 2) y = y - full;
        return 64'((x * y) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One operation on the WIDTH=6 instance with latency and handshake checks
    task automatic single(input string tag, input logic [5:0] a, input logic [5:0] b,
                          input bit s);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in1 = a; in2 = b; in_signed = s; out_ready = 1'b1;
        #1 chk({tag, " in_ready"}, 64'(in_ready6), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = ~a; in2 = ~b; in_signed = ~s;
        chk({tag, " busy"}, 64'(busy6), 64'(1));
        lat = 1;
        while (lat < 20) begin
            @(posedge clk); #1;
            if (out_valid6) break;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(4));
        chk({tag, " product"}, 64'(out6), model(6, int'(a), int'(b), s));
        @(posedge clk); #1;
        chk({tag, " consumed"}, 64'(out_valid6), 64'(0));
        chk({tag, " idle ready"}, 64'(in_ready6), 64'(1));
    endtask

    // Streams sq_* through the chosen instance; stall=0 also checks 5-cycle spacing
    task automatic stream(input int w, input bit stall);
        int n = sq_a.size();
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int last_out = -1;
        logic [63:0] expq[$];
        logic ov, rdy;
        logic [63:0] o;
        while (got < n && cyc < n * 40 + 100) begin
            @(negedge clk);
            in_valid = (idx < n);
            if (idx < n) begin
                in1 = 6'(sq_a[idx]); in2 = 6'(sq_b[idx]); in_signed = sq_s[idx];
            end
            out_ready = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
            #1;
            ov  = (w == 5) ? out_valid5 : out_valid6;
            rdy = (w == 5) ? in_ready5 : in_ready6;
            o   = (w == 5) ? 64'(out5) : 64'(out6);
            if (ov && out_ready) begin
                if (expq.size() == 0) chk("spurious product", 64'(1), 64'(0));
                else begin
                    chk($sformatf("w%0d product #%0d", w, got), o, expq.pop_front());
                    if (!stall && last_out >= 0)
                        chk("back-to-back gap", 64'(cyc - last_out), 64'(5));
                    last_out = cyc;
                end
                got++;
            end
            if (in_valid && rdy) begin
                expq.push_back(model(w, sq_a[idx], sq_b[idx], sq_s[idx]));
                idx++;
            end
            cyc++;
        end
        if (got < n) chk("stream timeout", 64'(got), 64'(n));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("stream drained", 64'((w == 5) ? out_valid5 : out_valid6), 64'(0));
        sq_a.delete(); sq_b.delete(); sq_s.delete();
    endtask

    initial begin
        logic [11:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(out_valid6), 64'(0));
        chk("reset busy", 64'(busy6), 64'(0));
        chk("reset out", 64'(out6), 64'(0));
        rst_n = 1'b1;
        #1 chk("reset in_ready", 64'(in_ready6), 64'(1));

        // Extremes
        single("signed -32*-32", 6'h20, 6'h20, 1'b1);
        chk("signed -32*-32 value", 64'(out6), 64'(12'h400));
        single("unsigned 63*63", 6'h3F, 6'h3F, 1'b0);
        chk("unsigned 63*63 value", 64'(out6), 64'(12'hF81));
        single("signed -1*-1", 6'h3F, 6'h3F, 1'b1);
        chk("signed -1*-1 value", 64'(out6), 64'(12'h001));
        single("zero", 6'h00, 6'h2B, 1'b1);

        // Backpressure: result held for 10 cycles, input pulses ignored
        @(negedge clk);
        in_valid = 1'b1; in1 = 6'h15; in2 = 6'h2E; in_signed = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid6; k++) @(negedge clk);
        held = out6;
        chk("bp product", 64'(held), model(6, 'h15, 'h2E, 1'b1));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; in1 = 6'($urandom); in2 = 6'($urandom);
            #1 chk("bp in_ready", 64'(in_ready6), 64'(0));
            @(negedge clk);
            chk("bp out_valid", 64'(out_valid6), 64'(1));
            chk("bp out stable", 64'(out6), 64'(held));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp released", 64'(out_valid6), 64'(0));
        chk("bp idle busy", 64'(busy6), 64'(0));
        chk("bp idle ready", 64'(in_ready6), 64'(1));

        // Reset during RUN step 2
        @(negedge clk);
        in_valid = 1'b1; in1 = 6'h1A; in2 = 6'h27; in_signed = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset busy", 64'(busy6), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(out_valid6), 64'(0));
        chk("mid reset busy", 64'(busy6), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post reset out_valid", 64'(out_valid6), 64'(0));
        single("after reset -1*31", 6'h3F, 6'h1F, 1'b1);

        // Back-to-back, three pairs
        for (int k = 0; k < 3; k++) begin
            sq_a.push_back(int'($urandom_range(0, 63)));
            sq_b.push_back(int'($urandom_range(0, 63)));
            sq_s.push_back(k[0]);
        end
        stream(6, 1'b0);

        // Random operands and modes, with stalls
        for (int k = 0; k < 200; k++) begin
            sq_a.push_back(int'($urandom_range(0, 63)));
            sq_b.push_back(int'($urandom_range(0, 63)));
            sq_s.push_back(1'($urandom));
        end
        stream(6, 1'b1);

        // Exhaustive WIDTH=6, both modes
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++)
                for (int j = 0; j < 64; j++) begin
                    sq_a.push_back(i); sq_b.push_back(j); sq_s.push_back(s[0]);
                end
        stream(6, 1'b1);

        // Exhaustive signed WIDTH=5
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                sq_a.push_back(i); sq_b.push_back(j); sq_s.push_back(1'b1);
            end
        stream(5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
